// File: rtl/rr_burst_arbiter_if.sv
// Bundle of requester-side and downstream-side signals for rr_burst_arbiter.
//   slave  : the arbiter (consumes requests and out_ready, drives grant/channel)
//   master : the environment (drives requests and out_ready)
// Signals:
//   req_valid_i/req_last_i/req_data_i : per-requester valid, last flag, payload
//   req_ready_o                       : per-requester ready
//   out_valid_o/out_data_o/out_last_o : downstream channel
//   out_ready_i                       : downstream ready
//   grant_o/grant_idx_o               : one-hot grant and its binary index
//   locked_o                          : high while a burst holds the channel
interface rr_burst_arbiter_if #(
   parameter int INPUTS = 4,
   parameter int WIDTH  = 16,
   parameter int IDX_W  = (INPUTS > 1) ? $clog2(INPUTS) : 1
);
   logic [INPUTS-1:0]            req_valid_i;
   logic [INPUTS-1:0]            req_last_i;
   logic [INPUTS-1:0][WIDTH-1:0] req_data_i;
   logic [INPUTS-1:0]            req_ready_o;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic [WIDTH-1:0]             out_data_o;
   logic                         out_last_o;
   logic [INPUTS-1:0]            grant_o;
   logic [IDX_W-1:0]             grant_idx_o;
   logic                         locked_o;

   modport slave (
      input  req_valid_i, req_last_i, req_data_i, out_ready_i,
      output req_ready_o, out_valid_o, out_data_o, out_last_o,
             grant_o, grant_idx_o, locked_o
   );

   modport master (
      output req_valid_i, req_last_i, req_data_i, out_ready_i,
      input  req_ready_o, out_valid_o, out_data_o, out_last_o,
             grant_o, grant_idx_o, locked_o
   );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst locking sharing one valid/ready channel
// between INPUTS requesters. A winner keeps the channel until its beat
// carrying last is accepted. Payload and valid pass through combinationally.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_burst_arbiter_if.slave (requests, downstream channel, grant)
//
// state  | meaning
// IDLE   | grant chosen combinationally by rotating scan from prio_q
// LOCKED | grant pinned to lock_grant_q until the last beat transfers
module rr_burst_arbiter #(
   parameter int INPUTS = 4,
   parameter int WIDTH  = 16,
   parameter int IDX_W  = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
   input logic              clk,
   input logic              rst_n,
   rr_burst_arbiter_if.slave bus
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  prio_q;
   logic [IDX_W-1:0]  prio_d;
   logic [INPUTS-1:0] lock_grant_q;
   logic              locked_q;

   logic [INPUTS-1:0] arb_grant;
   logic [INPUTS-1:0] grant;
   logic [IDX_W-1:0]  grant_idx;
   logic [WIDTH-1:0]  data_sel;
   logic              valid_sel;
   logic              last_sel;
   logic              xfer;

   // Rotating priority scan: first valid requester at or above prio_q, wrapping.
   always_comb begin : arb
      int   idx;
      logic found;
      arb_grant = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < INPUTS; i++) begin
         idx = int'(prio_q) + i;
         if (idx >= INPUTS) idx = idx - INPUTS;
         if (!found && bus.req_valid_i[idx]) begin
            arb_grant[idx] = 1'b1;
            found          = 1'b1;
         end
      end
   end

   // Grant depends only on state and req_valid_i, never on out_ready_i.
   assign grant = (state_q == LOCKED) ? lock_grant_q : arb_grant;

   always_comb begin
      grant_idx = '0;
      data_sel  = '0;
      for (int i = 0; i < INPUTS; i++) begin
         if (grant[i]) grant_idx = IDX_W'(i);
         data_sel = data_sel | ({WIDTH{grant[i]}} & bus.req_data_i[i]);
      end
   end

   assign valid_sel = |(grant & bus.req_valid_i);
   assign last_sel  = |(grant & bus.req_last_i);
   assign xfer      = valid_sel & bus.out_ready_i;
   assign prio_d    = (grant_idx == IDX_W'(INPUTS - 1)) ? '0 : grant_idx + IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         prio_q       <= '0;
         lock_grant_q <= '0;
         locked_q     <= 1'b0;
      end else if (xfer) begin
         case (state_q)
            IDLE: begin
               if (last_sel) begin
                  prio_q <= prio_d;
               end else begin
                  state_q      <= LOCKED;
                  lock_grant_q <= grant;
                  locked_q     <= 1'b1;
               end
            end
            LOCKED: begin
               if (last_sel) begin
                  state_q      <= IDLE;
                  prio_q       <= prio_d;
                  lock_grant_q <= '0;
                  locked_q     <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant_o     = grant;
   assign bus.grant_idx_o = grant_idx;
   assign bus.out_valid_o = valid_sel;
   assign bus.out_last_o  = last_sel;
   assign bus.out_data_o  = data_sel;
   assign bus.req_ready_o = grant & {INPUTS{bus.out_ready_i}};
   assign bus.locked_o    = locked_q;

   a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant));
   a_ready_subset : assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req_ready_o & ~grant) == '0);
   a_lock_grant   : assert property (@(posedge clk) disable iff (!rst_n)
      locked_q |-> (grant == lock_grant_q && lock_grant_q != '0));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
module tb_rr_burst_arbiter;
   localparam int N = 4;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rr_burst_arbiter_if #(.INPUTS(N), .WIDTH(W)) bus ();

   rr_burst_arbiter #(.INPUTS(N), .WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int         gidx;
      logic [W-1:0] data;
      logic       last;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] dv(input int i, input int b);
      return 16'hA000 | W'(i << 8) | W'(b);
   endfunction

   task automatic exp_push(input int g, input int b, input logic l);
      exp_t e;
      e.gidx = g;
      e.data = dv(g, b);
      e.last = l;
      sbq.push_back(e);
   endtask

   task automatic reset_data();
      for (int i = 0; i < N; i++) bus.req_data_i[i] = dv(i, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every accepted beat must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_grant", 32'(bus.grant_o), 32'(1 << e.gidx));
            chk("sb_idx", 32'(bus.grant_idx_o), 32'(e.gidx));
            chk("sb_data", 32'(bus.out_data_o), 32'(e.data));
            chk("sb_last", 32'(bus.out_last_o), 32'(e.last));
            chk("sb_ready", 32'(bus.req_ready_o), 32'(1 << e.gidx));
         end
      end
   end

   initial begin
      bus.req_valid_i = '0;
      bus.req_last_i  = '0;
      bus.out_ready_i = 1'b0;
      reset_data();
      #12;
      chk("rst_grant", 32'(bus.grant_o), 32'd0);
      chk("rst_idx", 32'(bus.grant_idx_o), 32'd0);
      chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("rst_data", 32'(bus.out_data_o), 32'd0);
      chk("rst_last", 32'(bus.out_last_o), 32'd0);
      chk("rst_locked", 32'(bus.locked_o), 32'd0);
      #1 rst_n = 1'b1;
      step();

      // Single request from req0 right after reset, then prio moves to 1.
      bus.req_valid_i = 4'b0001;
      bus.req_last_i  = 4'b1111;
      bus.out_ready_i = 1'b1;
      exp_push(0, 0, 1'b1);
      step();
      bus.req_valid_i = 4'b0011;
      bus.out_ready_i = 1'b0;
      #2;
      chk("p1_prio1_grant", 32'(bus.grant_o), 32'b0010);
      chk("p1_stall_ready", 32'(bus.req_ready_o), 32'b0000);
      // Winner 3 wraps prio back to 0.
      bus.req_valid_i = 4'b1000;
      bus.out_ready_i = 1'b1;
      exp_push(3, 0, 1'b1);
      step();

      // All four single-beat: strict rotation 0,1,2,3,0,1,2,3.
      bus.req_valid_i = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         exp_push(k % N, 0, 1'b1);
         step();
      end
      bus.req_valid_i = '0;

      // 3-beat burst from req2 against competing requesters.
      bus.req_valid_i = 4'b0010;
      exp_push(1, 0, 1'b1);
      step();
      bus.req_valid_i = 4'b1111;
      bus.req_last_i  = 4'b1011;
      exp_push(2, 0, 1'b0);
      #2 chk("p3_locked_b1", 32'(bus.locked_o), 32'd0);
      step();
      bus.req_data_i[2] = dv(2, 1);
      exp_push(2, 1, 1'b0);
      #2 chk("p3_locked_b2", 32'(bus.locked_o), 32'd1);
      step();
      bus.req_data_i[2] = dv(2, 2);
      bus.req_last_i    = 4'b1111;
      exp_push(2, 2, 1'b1);
      #2 chk("p3_locked_b3", 32'(bus.locked_o), 32'd1);
      step();
      exp_push(3, 0, 1'b1);
      #2;
      chk("p3_after_grant", 32'(bus.grant_o), 32'b1000);
      chk("p3_after_locked", 32'(bus.locked_o), 32'd0);
      step();
      bus.req_valid_i = '0;

      // Burst from req1 stalled by out_ready_i=0 for 5 cycles.
      reset_data();
      bus.req_valid_i = 4'b0010;
      bus.req_last_i  = 4'b1101;
      exp_push(1, 0, 1'b0);
      step();
      bus.req_valid_i   = 4'b1111;
      bus.req_data_i[1] = dv(1, 1);
      bus.out_ready_i   = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #2;
         chk("p4_stall_valid", 32'(bus.out_valid_o), 32'd1);
         chk("p4_stall_ready", 32'(bus.req_ready_o), 32'b0000);
         chk("p4_stall_grant", 32'(bus.grant_o), 32'b0010);
         chk("p4_stall_locked", 32'(bus.locked_o), 32'd1);
         chk("p4_stall_data", 32'(bus.out_data_o), 32'(dv(1, 1)));
         step();
      end
      bus.out_ready_i = 1'b1;
      exp_push(1, 1, 1'b0);
      step();
      bus.req_data_i[1] = dv(1, 2);
      bus.req_last_i    = 4'b1111;
      exp_push(1, 2, 1'b1);
      step();
      exp_push(2, 0, 1'b1);
      #2 chk("p4_next_grant", 32'(bus.grant_o), 32'b0100);
      step();
      bus.req_valid_i = '0;

      // Req3 burst with a 2-cycle valid bubble while req0 waits.
      reset_data();
      bus.req_valid_i = 4'b1001;
      bus.req_last_i  = 4'b0001;
      exp_push(3, 0, 1'b0);
      step();
      bus.req_valid_i = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         #2;
         chk("p5_bubble_valid", 32'(bus.out_valid_o), 32'd0);
         chk("p5_bubble_grant", 32'(bus.grant_o), 32'b1000);
         chk("p5_req0_ready", 32'(bus.req_ready_o[0]), 32'd0);
         chk("p5_bubble_locked", 32'(bus.locked_o), 32'd1);
         step();
      end
      bus.req_valid_i   = 4'b1001;
      bus.req_data_i[3] = dv(3, 1);
      bus.req_last_i    = 4'b1001;
      exp_push(3, 1, 1'b1);
      step();
      exp_push(0, 0, 1'b1);
      step();
      bus.req_valid_i = '0;

      // Asynchronous reset in the middle of a burst from req1.
      reset_data();
      bus.req_valid_i = 4'b0010;
      bus.req_last_i  = 4'b0000;
      exp_push(1, 0, 1'b0);
      step();
      bus.out_ready_i = 1'b0;
      #1 chk("p6_locked_before", 32'(bus.locked_o), 32'd1);
      rst_n = 1'b0;
      #1 chk("p6_locked_async", 32'(bus.locked_o), 32'd0);
      bus.req_valid_i = 4'b1111;
      bus.req_last_i  = 4'b1111;
      #1 rst_n = 1'b1;
      chk("p6_grant_after", 32'(bus.grant_o), 32'b0001);
      bus.out_ready_i = 1'b1;
      exp_push(0, 0, 1'b1);
      step();
      bus.req_valid_i = '0;
      step();

      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
